// File: rtl/bus_master_pkg.sv
// -----------------------------------------------------------------------------
// bus_master_pkg
// Shared definitions for the peripheral bus cycle master:
//   - state_t     : cycle FSM states (IDLE, SETUP, STROBE, HOLD, DONE)
//   - DATA_W      : data bus width (8)
//   - DEF_*_CYC   : default phase lengths in clock cycles
//   - max3 / cnt_width : helpers to size the shared phase down-counter
// No ports (package).
// -----------------------------------------------------------------------------
package bus_master_pkg;

    localparam int DATA_W         = 8;
    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_STROBE_CYC = 2;
    localparam int DEF_HOLD_CYC   = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Counter holds values 0 .. max_cyc-1; never narrower than one bit.
    function automatic int cnt_width(input int max_cyc);
        return (max_cyc > 1) ? $clog2(max_cyc) : 1;
    endfunction

endpackage

// File: rtl/bus_cycle_timer.sv
// -----------------------------------------------------------------------------
// bus_cycle_timer
// Loadable down-counter with a zero flag. Counts down once per clock until it
// reaches zero and then rests there; a load takes priority over counting.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (count -> 0)
//   load     in   load load_val at the next edge
//   load_val in   CNT_W value to load
//   zero     out  count == 0
// -----------------------------------------------------------------------------
module bus_cycle_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bus_cycle_master.sv
// -----------------------------------------------------------------------------
// bus_cycle_master
// Turns single-cycle internal read/write requests into timed active-low
// CS_n / WR_n / RD_n strobe cycles on an 8-bit bidirectional data bus.
//
// Handshake: a request is taken at a rising edge where Req=1 and Ready=1.
// Req while Ready=0 is simply dropped (no queue, no error). Done pulses for
// exactly one cycle when the bus cycle is complete; RdData is valid from then
// until the next read completes.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   Req, Write      request strobe and direction (1 = write)
//   Addr, WrData    register address and write data, sampled with Req
//   Ready           FSM is idle and will accept Req at the next edge
//   Done            one-cycle completion pulse
//   RdData          data captured by the most recent completed read
//   CS_n/WR_n/RD_n  registered active-low bus strobes
//   A               registered address to the peripheral
//   DataBus         shared bidirectional data bus
//   dbg_state       current FSM state
// -----------------------------------------------------------------------------
module bus_cycle_master
    import bus_master_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int ADDR_W     = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req,
    input  logic              Write,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WrData,
    output logic              Ready,
    output logic              Done,
    output logic [DATA_W-1:0] RdData,
    output logic              CS_n,
    output logic              WR_n,
    output logic              RD_n,
    output logic [ADDR_W-1:0] A,
    inout  wire  [DATA_W-1:0] DataBus,
    output state_t            dbg_state
);

    localparam int MAX_CYC = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int CNT_W   = cnt_width(MAX_CYC);

    // Each phase loads N-1 so that it lasts N cycles ending on count == 0.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    state_t              state, state_d;
    logic                accept;
    logic                load;
    logic [CNT_W-1:0]    load_val;
    logic                cnt_zero;

    logic                write_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                bus_en;

    logic                write_sel;
    logic                active_d;
    logic                cs_n_d, wr_n_d, rd_n_d, bus_en_d, done_d;
    logic                rd_capture;

    bus_cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (load),
        .load_val (load_val),
        .zero     (cnt_zero)
    );

    // Next-state logic; the counter is reloaded on entry to each timed phase.
    always_comb begin
        state_d  = state;
        accept   = 1'b0;
        load     = 1'b0;
        load_val = SETUP_LD;
        case (state)
            IDLE: begin
                if (Req) begin
                    accept   = 1'b1;
                    state_d  = SETUP;
                    load     = 1'b1;
                    load_val = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d  = STROBE;
                    load     = 1'b1;
                    load_val = STROBE_LD;
                end
            end
            STROBE: begin
                if (cnt_zero) begin
                    state_d  = HOLD;
                    load     = 1'b1;
                    load_val = HOLD_LD;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so every bus
    // strobe changes only at a clock edge and lines up with the state.
    always_comb begin
        write_sel  = accept ? Write : write_q;
        active_d   = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        cs_n_d     = !active_d;
        wr_n_d     = !((state_d == STROBE) && write_sel);
        rd_n_d     = !((state_d == STROBE) && !write_sel);
        bus_en_d   = active_d && write_sel;
        done_d     = (state_d == DONE);
        // Last STROBE cycle of a read: RD_n is still low while we sample.
        rd_capture = (state == STROBE) && cnt_zero && !write_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            CS_n      <= 1'b1;
            WR_n      <= 1'b1;
            RD_n      <= 1'b1;
            A         <= '0;
            Done      <= 1'b0;
            bus_en    <= 1'b0;
            RdData    <= '0;
            write_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state  <= state_d;
            CS_n   <= cs_n_d;
            WR_n   <= wr_n_d;
            RD_n   <= rd_n_d;
            Done   <= done_d;
            bus_en <= bus_en_d;
            if (accept) begin
                write_q   <= Write;
                wr_data_q <= WrData;
                A         <= Addr;
            end
            if (rd_capture) begin
                RdData <= DataBus;
            end
        end
    end

    // bus_en is only ever set for write cycles, so the bus is never driven
    // while RD_n is low.
    assign DataBus   = bus_en ? wr_data_q : {DATA_W{1'bz}};
    assign Ready     = (state == IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_bus_cycle_master.sv
// -----------------------------------------------------------------------------
// tb_bus_cycle_master
// Two instances: g_dut[0] with default timing (1/2/1) and g_dut[1] with
// 2/4/3. Each instance has a transaction-level model (cycle offset since the
// accepting edge) that predicts every output each cycle, and a peripheral
// responder that drives read data while RD_n is low. When neither the master
// nor the responder should drive, the bench holds the bus at 0x00 so that a
// stray master drive shows up as a wrong bus value.
// -----------------------------------------------------------------------------
module tb_bus_cycle_master;

  logic clk;
  logic rst;

  logic [1:0]       drv_req;
  logic [1:0]       drv_write;
  logic [1:0][1:0]  drv_addr;
  logic [1:0][7:0]  drv_wdata;
  logic [7:0]       rsp_data;

  logic [1:0]       obs_ready;
  logic [1:0]       obs_done;
  logic [1:0]       obs_cs_n;
  logic [1:0]       obs_wr_n;
  logic [1:0]       obs_rd_n;
  logic [1:0][1:0]  obs_a;
  logic [1:0][7:0]  obs_rd_data;
  logic [1:0][7:0]  obs_bus;
  logic [1:0][2:0]  obs_dbg;

  int n_cmp;
  int n_bad;
  bit chk_on;

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- check
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_val);
    n_cmp++;
    if (act !== req_val) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req_val, $time);
    end
  endtask

  // ------------------------------------------------- DUTs, models, compare
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int S = (g == 0) ? 1 : 2;
    localparam int T = (g == 0) ? 2 : 4;
    localparam int H = (g == 0) ? 1 : 3;

    wire  [7:0] bus;
    logic       m_busy = 1'b0;
    logic       m_wr   = 1'b0;
    int         m_off  = 0;
    logic [1:0] m_a    = 2'd0;
    logic [7:0] m_wd   = 8'h00;
    logic [7:0] m_rd   = 8'h00;
    logic       m_act, m_stb, m_drv;
    logic [7:0] tb_val;

    // Offsets 1..S+T+H are the CS_n-low cycles; offset S+T+H+1 is Done.
    assign m_act  = m_busy && (m_off <= S + T + H);
    assign m_stb  = m_busy && (m_off > S) && (m_off <= S + T);
    assign m_drv  = m_act && m_wr;
    assign tb_val = !obs_rd_n[g] ? rsp_data : 8'h00;
    assign bus    = m_drv ? 8'bz : tb_val;
    assign obs_bus[g] = bus;

    bus_cycle_master #(
      .SETUP_CYC  (S),
      .STROBE_CYC (T),
      .HOLD_CYC   (H),
      .ADDR_W     (2)
    ) u_dut (
      .CLK       (clk),
      .RST       (rst),
      .Req       (drv_req[g]),
      .Write     (drv_write[g]),
      .Addr      (drv_addr[g]),
      .WrData    (drv_wdata[g]),
      .Ready     (obs_ready[g]),
      .Done      (obs_done[g]),
      .RdData    (obs_rd_data[g]),
      .CS_n      (obs_cs_n[g]),
      .WR_n      (obs_wr_n[g]),
      .RD_n      (obs_rd_n[g]),
      .A         (obs_a[g]),
      .DataBus   (bus),
      .dbg_state (obs_dbg[g])
    );

    always @(posedge clk) begin
      if (rst) begin
        m_busy <= 1'b0;
        m_off  <= 0;
        m_rd   <= 8'h00;
        m_a    <= 2'd0;
      end else if (m_busy) begin
        if (!m_wr && (m_off == S + T)) m_rd <= rsp_data;
        if (m_off == S + T + H + 1) m_busy <= 1'b0;
        else                        m_off  <= m_off + 1;
      end else if (drv_req[g]) begin
        m_busy <= 1'b1;
        m_off  <= 1;
        m_wr   <= drv_write[g];
        m_a    <= drv_addr[g];
        m_wd   <= drv_wdata[g];
      end
    end

    always @(negedge clk) begin
      if (chk_on) begin
        logic [7:0] exp_bus;
        exp_bus = m_drv ? m_wd : ((m_stb && !m_wr) ? rsp_data : 8'h00);
        check($sformatf("d%0d cs_n", g),    32'(obs_cs_n[g]),    32'(!m_act));
        check($sformatf("d%0d wr_n", g),    32'(obs_wr_n[g]),    32'(!(m_stb && m_wr)));
        check($sformatf("d%0d rd_n", g),    32'(obs_rd_n[g]),    32'(!(m_stb && !m_wr)));
        check($sformatf("d%0d done", g),    32'(obs_done[g]),    32'(m_busy && (m_off == S + T + H + 1)));
        check($sformatf("d%0d ready", g),   32'(obs_ready[g]),   32'(!m_busy));
        check($sformatf("d%0d a", g),       32'(obs_a[g]),       32'(m_a));
        check($sformatf("d%0d rd_data", g), 32'(obs_rd_data[g]), 32'(m_rd));
        check($sformatf("d%0d bus", g),     32'(obs_bus[g]),     32'(exp_bus));
        check($sformatf("d%0d idle_state", g),
              32'(obs_dbg[g] == 3'(bus_master_pkg::IDLE)), 32'(!m_busy));
      end
    end
  end

  // ---------------------------------------------------------------- driver
  // Raises Req for one edge; the DUT must be idle at that edge. Returns
  // 2 time units into cycle 1 of the accepted transaction.
  task automatic do_req(input int d, input logic w, input logic [1:0] ad, input logic [7:0] wd);
    @(posedge clk); #2;
    drv_req[d]   = 1'b1;
    drv_write[d] = w;
    drv_addr[d]  = ad;
    drv_wdata[d] = wd;
    @(posedge clk); #2;
    drv_req[d]   = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [15:0] cs_s, wr_s, rd_s, dn_s, rdy_s;
    int nd, nf;
    logic prev_wr;

    n_cmp = 0; n_bad = 0; chk_on = 1'b0;
    rst = 1'b1; drv_req = '0; drv_write = '0; drv_addr = '0; drv_wdata = '0;
    rsp_data = 8'h00;
    cs_s = '0; wr_s = '0; rd_s = '0; dn_s = '0; rdy_s = '0;

    repeat (2) @(posedge clk);
    #1 chk_on = 1'b1;

    // Reset state of both instances
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst cs_n",    32'(obs_cs_n[d]),    32'(1));
      check("rst wr_n",    32'(obs_wr_n[d]),    32'(1));
      check("rst rd_n",    32'(obs_rd_n[d]),    32'(1));
      check("rst done",    32'(obs_done[d]),    32'(0));
      check("rst rd_data", 32'(obs_rd_data[d]), 32'(8'h00));
      check("rst a",       32'(obs_a[d]),       32'(0));
      check("rst ready",   32'(obs_ready[d]),   32'(1));
    end
    @(posedge clk); #2 rst = 1'b0;

    // Default write, Addr=2, WrData=0xA5
    do_req(0, 1'b1, 2'd2, 8'hA5);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      cs_s[k-1]  = obs_cs_n[0];
      wr_s[k-1]  = obs_wr_n[0];
      rd_s[k-1]  = obs_rd_n[0];
      dn_s[k-1]  = obs_done[0];
      rdy_s[k-1] = obs_ready[0];
      if (k == 3) check("t1 a", 32'(obs_a[0]), 32'(2));
      if (k == 4) check("t1 bus", 32'(obs_bus[0]), 32'(8'hA5));
    end
    check("t1 cs_n cycles",  32'(cs_s[5:0]),  32'(6'b110000));
    check("t1 wr_n cycles",  32'(wr_s[5:0]),  32'(6'b111001));
    check("t1 rd_n cycles",  32'(rd_s[5:0]),  32'(6'b111111));
    check("t1 done cycles",  32'(dn_s[5:0]),  32'(6'b010000));
    check("t1 ready cycles", 32'(rdy_s[5:0]), 32'(6'b100000));

    // Default read, Addr=1, responder returns 0x3C
    rsp_data = 8'h3C;
    do_req(0, 1'b0, 2'd1, 8'hC3);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      rd_s[k-1] = obs_rd_n[0];
      wr_s[k-1] = obs_wr_n[0];
      if (k == 5) begin
        check("t2 done", 32'(obs_done[0]), 32'(1));
        check("t2 rd_data", 32'(obs_rd_data[0]), 32'(8'h3C));
      end
    end
    check("t2 rd_n cycles", 32'(rd_s[5:0]), 32'(6'b111001));
    check("t2 wr_n cycles", 32'(wr_s[5:0]), 32'(6'b111111));

    // Req held high for two writes (0x11 then 0x22)
    @(posedge clk); #2;
    drv_req[0] = 1'b1; drv_write[0] = 1'b1; drv_addr[0] = 2'd3; drv_wdata[0] = 8'h11;
    @(posedge clk); #2;
    drv_wdata[0] = 8'h22;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      cs_s[k-1] = obs_cs_n[0];
      dn_s[k-1] = obs_done[0];
      if (k == 3) check("t3 bus first", 32'(obs_bus[0]), 32'(8'h11));
      if (k == 8) check("t3 bus second", 32'(obs_bus[0]), 32'(8'h22));
      if (k == 7) begin #1 drv_req[0] = 1'b0; end
    end
    check("t3 cs_n cycles", 32'(cs_s[11:0]), 32'(12'b1100_0011_0000));
    check("t3 done cycles", 32'(dn_s[11:0]), 32'(12'b0100_0001_0000));

    // Reset during cycle 2 of a read
    rsp_data = 8'h77;
    do_req(0, 1'b0, 2'd1, 8'hC3);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    check("t4 rd_n before rst", 32'(obs_rd_n[0]), 32'(0));
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("t4 cs_n",    32'(obs_cs_n[0]),    32'(1));
    check("t4 rd_n",    32'(obs_rd_n[0]),    32'(1));
    check("t4 rd_data", 32'(obs_rd_data[0]), 32'(8'h00));
    check("t4 ready",   32'(obs_ready[0]),   32'(1));
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      if (obs_done[0]) nd++;
      @(negedge clk);
    end
    check("t4 no done", 32'(nd), 32'(0));

    // Req pulsed during STROBE of an active write is ignored
    do_req(0, 1'b1, 2'd0, 8'h5E);
    nd = 0; nf = 0; prev_wr = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!obs_wr_n[0] && prev_wr) nf++;
      prev_wr = obs_wr_n[0];
      if (obs_done[0]) nd++;
      if (k == 2) begin
        #1;
        drv_req[0] = 1'b1; drv_write[0] = 1'b0; drv_addr[0] = 2'd3; drv_wdata[0] = 8'hFF;
      end
      if (k == 3) begin #1 drv_req[0] = 1'b0; end
    end
    check("t5 done pulses", 32'(nd), 32'(1));
    check("t5 wr_n pulses", 32'(nf), 32'(1));

    // 2/4/3 timing instance: write then read
    do_req(1, 1'b1, 2'd1, 8'h96);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      cs_s[k-1] = obs_cs_n[1];
      wr_s[k-1] = obs_wr_n[1];
      dn_s[k-1] = obs_done[1];
    end
    check("t6 cs_n cycles", 32'(cs_s[10:0]), 32'(11'b110_0000_0000));
    check("t6 wr_n cycles", 32'(wr_s[10:0]), 32'(11'b111_1100_0011));
    check("t6 done cycles", 32'(dn_s[10:0]), 32'(11'b010_0000_0000));

    rsp_data = 8'h81;
    do_req(1, 1'b0, 2'd2, 8'h7E);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      rd_s[k-1] = obs_rd_n[1];
      if (k == 10) begin
        check("t6 read done", 32'(obs_done[1]), 32'(1));
        check("t6 rd_data", 32'(obs_rd_data[1]), 32'(8'h81));
      end
    end
    check("t6 rd_n cycles", 32'(rd_s[10:0]), 32'(11'b111_1100_0011));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bus_cycle_master.md
# bus_cycle_master

Initiator-side peripheral bus interface: converts single-cycle internal read/write requests into timed, active-low chip-select/read/write strobe cycles on an 8-bit bidirectional data bus. It is the CPU end of the data bus buffer interface used by the peripheral blocks. During writes it drives the bus and the peripheral captures data on its write strobe. During reads it releases the bus, and read data is sampled at the end of the read strobe.

## Interface
- SETUP_CYC, default 1: cycles with CS_n/A valid before the strobe falls; minimum 1.
- STROBE_CYC, default 2: cycles WR_n or RD_n stays low; minimum 1.
- HOLD_CYC, default 1: cycles with CS_n/A (and write data) held after the strobe rises; minimum 1.
- ADDR_W, default 2: width of register address A.
- CLK  in  1  sole clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- Req  in  1  request; sampled only while Ready=1.
- Write  in  1  1 = write cycle, 0 = read cycle; sampled with Req.
- Addr  in  ADDR_W  register address; sampled with Req.
- WrData  in  8  write data; sampled with Req.
- Ready  out  1  block idle, will accept Req at the next edge.
- Done  out  1  one-cycle pulse at cycle completion.
- RdData  out  8  data captured by the last read; holds until the next read completes.
- CS_n  out  1  chip select, active low.
- WR_n  out  1  write strobe, active low.
- RD_n  out  1  read strobe, active low.
- A  out  ADDR_W  address to peripheral.
- DataBus  inout  8  shared data bus.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: Ready=1. Req=1 at an edge latches Write/Addr/WrData and moves the FSM to SETUP.
- SETUP, lasting SETUP_CYC cycles: CS_n=0, A=latched Addr, WR_n=RD_n=1.
- STROBE, lasting STROBE_CYC cycles: CS_n=0, and WR_n=0 (write) or RD_n=0 (read).
- HOLD, lasting HOLD_CYC cycles: CS_n=0, WR_n=RD_n=1.
- DONE, lasting 1 cycle: Done=1, CS_n=1, A retains its value, bus released, Ready=0. Then IDLE.
- DataBus drive: driven with latched WrData only when Write=1 and state is SETUP, STROBE or HOLD; otherwise high-Z. The block never drives the bus while RD_n=0.
- Read capture: RdData loads DataBus at the edge that ends the last STROBE cycle.
- Registered outputs: CS_n, WR_n, RD_n, A, Done and the bus-enable are all registered (glitch-free). Ready is decoded from state==IDLE.
- Cycle counting: a single down-counter, width clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC)). It reloads on each state entry, and the state advances when the count reaches 0.
- Req outside IDLE is ignored; there is no queue and no error.

## Timing
- Reset values: CS_n=1, WR_n=1, RD_n=1, A=0, RdData=0x00, Done=0, DataBus high-Z, state IDLE (Ready=1 from the first cycle after the reset edge).
- Accept at edge E0. CS_n falls in cycle 1. The strobe is low in cycles SETUP_CYC+1 .. SETUP_CYC+STROBE_CYC. CS_n rises after cycle SETUP_CYC+STROBE_CYC+HOLD_CYC. Done=1 in the next cycle.
- Defaults: CS_n low cycles 1-4, strobe low cycles 2-3, Done cycle 5, Ready again cycle 6.
- Throughput: one transaction per SETUP_CYC+STROBE_CYC+HOLD_CYC+2 cycles.
- Back-to-back: Req held high is accepted at the first edge where the FSM is in IDLE after DONE.
- Reset mid-cycle: at the RST edge, all strobes and CS_n go to 1, the bus is released, no Done is issued, and RdData is cleared. A partial read strobe does not update RdData.

## Structure
- Shared package bus_master_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, DONE);
  - default timing constants;
  - the data width constant 8.
- Sub-module bus_cycle_timer: a loadable down-counter with a zero flag, instanced once.
- The top level holds the FSM, request latch, output registers and the tristate assignment.

## Test plan
- Defaults, Req write Addr=2 WrData=0xA5 -> A=2 and CS_n=0 cycles 1-4; WR_n=0 cycles 2-3; DataBus=0xA5 cycles 1-4, Z otherwise; RD_n=1 throughout; Done=1 cycle 5 only.
- Defaults, read Addr=1, responder model drives 0x3C while RD_n=0 -> RdData=0x3C when Done=1; the block never drives DataBus (no contention with the model).
- Req held high for two writes (0x11, 0x22) -> second CS_n falls in cycle 7; Done pulses in cycles 5 and 11.
- RST asserted in cycle 2 of a read -> next cycle CS_n=RD_n=1, DataBus Z, RdData=0x00, no Done; Ready=1 after RST drops.
- Req pulsed during STROBE of an active write -> ignored; exactly one Done, one WR_n pulse.
- SETUP_CYC=2, STROBE_CYC=4, HOLD_CYC=3 -> WR_n low cycles 3-6, CS_n low cycles 1-9, Done cycle 10.
